fetch_predict: RTL

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and predicts the next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It forwards instruction, PC+4 and the prediction bit to IF/ID. It accepts resolution and redirect information from the execute stage, and raises the IF/ID flush on a misprediction.

---
 rtl/fetch_predict_pkg.sv | 38 +++
 rtl/fetch_predict_btb.sv | 81 ++++++++
 rtl/fetch_predict.sv | 69 ++++++
 3 files changed

// File: rtl/fetch_predict_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package fetch_predict_pkg;

  localparam int          BTB_ENTRIES_DEFAULT = 16;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          TAG_W               = 30;  // wide enough for the smallest index width

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_e             ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_predict_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup, synchronous update.
module branch_target_buffer
  import fetch_predict_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lkp_pc,
  output logic        lkp_hit,
  output logic        lkp_taken,
  output logic [31:0] lkp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IW = $clog2(ENTRIES);

  logic             valid_q  [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IW-1:0]    lkp_idx;
  logic [IW-1:0]    upd_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             ctr_we;
  logic             alloc_we;
  btb_entry_t       entry_d;
  logic             unused_byte_offset;

  assign unused_byte_offset = ^{lkp_pc[1:0], upd_pc[1:0]};

  assign lkp_idx = lkp_pc[IW+1:2];
  assign upd_idx = upd_pc[IW+1:2];
  assign lkp_tag = TAG_W'(lkp_pc >> (IW + 2));
  assign upd_tag = TAG_W'(upd_pc >> (IW + 2));

  // Lookup reads the stored state, so a same-cycle update is seen only next cycle.
  assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken  = ctr_q[lkp_idx][1];
  assign lkp_target = target_q[lkp_idx];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ctr_we         = upd_valid && (upd_hit || upd_taken);
    alloc_we       = upd_valid && upd_taken;
    entry_d.valid  = 1'b1;
    entry_d.tag    = upd_tag;
    entry_d.target = upd_target;
    entry_d.ctr    = upd_hit ? ctr_next(ctr_q[upd_idx], upd_taken) : CTR_ALLOC;
  end

  // NOTE: only valid and ctr are reset; tag/target are don't-care while invalid, so they live
  // in a separate reset-free process and can map onto plain storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (alloc_we) valid_q[upd_idx] <= entry_d.valid;
      if (ctr_we)   ctr_q[upd_idx]   <= entry_d.ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_we) begin
      tag_q[upd_idx]    <= entry_d.tag;
      target_q[upd_idx] <= entry_d.target;
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Instruction-fetch stage: PC register, BTB-based next-PC prediction and redirect on mispredict.
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter int          BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction_out,
  output logic [31:0] PC4_out,
  output logic        prediction_out,
  output logic        flush_out,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic [31:0] upd_correct_pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pred_next;
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target;

  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lkp_pc     (pc_q),
    .lkp_hit    (btb_hit),
    .lkp_taken  (btb_taken),
    .lkp_target (btb_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  assign pc_plus4       = pc_q + 32'd4;
  assign prediction_out = btb_hit && btb_taken;
  assign pred_next      = prediction_out ? btb_target : pc_plus4;

  // A redirect from execute must win over a decode stall, or the wrong path would be held.
  always_comb begin
    pc_d = pc_q;
    if (upd_mispredict) pc_d = upd_correct_pc;
    else if (!stall)    pc_d = pred_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign imem_addr       = pc_q;
  assign instruction_out = imem_data;
  assign PC4_out         = pc_plus4;
  assign flush_out       = upd_mispredict;

endmodule
